// File: rtl/sparse_hdc_pkg.sv
// Shared encoder parameters and collector state type.
package sparse_hdc_pkg;

    localparam int unsigned HV_DIM      = 5000;
    localparam int unsigned DIMS_PER_CC = 500;
    localparam int unsigned NUM_CHUNKS  = HV_DIM / DIMS_PER_CC;
    localparam int unsigned CTR_W       = 4;
    localparam int unsigned DENS_W      = $clog2(HV_DIM + 1);
    localparam int unsigned PC_W        = $clog2(DIMS_PER_CC + 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } coll_state_t;

endpackage

// File: rtl/enc_chunk_popcount.sv
// Combinational popcount of one DIMS_PER_CC-wide chunk; only used by the density build.
module enc_chunk_popcount
    import sparse_hdc_pkg::*;
(
    input  logic [DIMS_PER_CC-1:0] in_bits,
    output logic [PC_W-1:0]        count_c
);

    // Flat sum; synthesis rebalances it into an adder tree.
    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < DIMS_PER_CC; i++) begin
            count_c = count_c + PC_W'(in_bits[i]);
        end
    end

endmodule

// File: rtl/enc_hv_collect.sv
// Collects per-chunk bundled bits into a full hypervector and owns the mux chunk counter.
// Optional density output enabled by defining ENC_HV_COLLECT_DENSITY_EN.
module enc_hv_collect
    import sparse_hdc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    output logic [CTR_W-1:0]       ctr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIMS_PER_CC-1:0] in_bits,
    output logic                   hv_valid,
    input  logic                   hv_ready,
    output logic [HV_DIM-1:0]      hv_out
`ifdef ENC_HV_COLLECT_DENSITY_EN
    ,
    output logic [DENS_W-1:0]      hv_density
`endif
);

    coll_state_t            r_state;
    coll_state_t            w_state_nxt;
    logic [CTR_W-1:0]       r_ctr;
    logic [CTR_W-1:0]       w_ctr_nxt;
    logic                   r_in_ready;
    logic                   w_in_ready_nxt;
    logic                   r_hv_valid;
    logic                   w_hv_valid_nxt;
    logic [HV_DIM-1:0]      r_hv;
    logic                   w_accept;
    logic                   w_clear;
    logic                   w_last;

    assign w_last = (r_ctr == CTR_W'(NUM_CHUNKS - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_COLLECT;
            r_ctr      <= '0;
            r_in_ready <= 1'b1;
            r_hv_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctr      <= w_ctr_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_hv_valid <= w_hv_valid_nxt;
        end
    end

    // Next-state logic; flush only acts while collecting and beats a coincident chunk.
    always_comb begin
        w_state_nxt    = r_state;
        w_ctr_nxt      = r_ctr;
        w_in_ready_nxt = r_in_ready;
        w_hv_valid_nxt = r_hv_valid;
        w_accept       = 1'b0;
        w_clear        = 1'b0;
        case (r_state)
            S_COLLECT: begin
                if (flush) begin
                    w_clear   = 1'b1;
                    w_ctr_nxt = '0;
                end else if (in_valid && r_in_ready) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_ctr_nxt      = '0;
                        w_state_nxt    = S_HOLD;
                        w_in_ready_nxt = 1'b0;
                        w_hv_valid_nxt = 1'b1;
                    end else begin
                        w_ctr_nxt = r_ctr + CTR_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (r_hv_valid && hv_ready) begin
                    w_state_nxt    = S_COLLECT;
                    w_in_ready_nxt = 1'b1;
                    w_hv_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = S_COLLECT;
                w_ctr_nxt      = '0;
                w_in_ready_nxt = 1'b1;
                w_hv_valid_nxt = 1'b0;
            end
        endcase
    end

    // Hypervector accumulator: chunk k lands in bits [k*DIMS_PER_CC +: DIMS_PER_CC].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hv <= '0;
        end else if (w_clear) begin
            r_hv <= '0;
        end else if (w_accept) begin
            for (int unsigned k = 0; k < NUM_CHUNKS; k++) begin
                if (r_ctr == CTR_W'(k)) begin
                    r_hv[k*DIMS_PER_CC +: DIMS_PER_CC] <= in_bits;
                end
            end
        end
    end

`ifdef ENC_HV_COLLECT_DENSITY_EN
    logic [PC_W-1:0]   w_pop;
    logic [DENS_W-1:0] r_dens;
    logic [DENS_W-1:0] w_dens_base;

    enc_chunk_popcount u_popcount (
        .in_bits (in_bits),
        .count_c (w_pop)
    );

    // Chunk 0 restarts the running count so a stale total never leaks into a new vector.
    assign w_dens_base = (r_ctr == '0) ? '0 : r_dens;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dens <= '0;
        end else if (w_clear) begin
            r_dens <= '0;
        end else if (w_accept) begin
            r_dens <= w_dens_base + DENS_W'(w_pop);
        end
    end

    assign hv_density = r_dens;
`endif

    assign ctr      = r_ctr;
    assign in_ready = r_in_ready;
    assign hv_valid = r_hv_valid;
    assign hv_out   = r_hv;

    a_ctr_range: assert property (@(posedge clk) disable iff (rst) r_ctr < CTR_W'(NUM_CHUNKS))
        else $error("ctr out of range: %0d", r_ctr);

endmodule

// File: tb/tb_enc_hv_collect.sv
// Directed self-checking bench for enc_hv_collect (density checks follow ENC_HV_COLLECT_DENSITY_EN).
module tb_enc_hv_collect;
    import sparse_hdc_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic [CTR_W-1:0]       ctr;
    logic                   in_valid;
    logic                   in_ready;
    logic [DIMS_PER_CC-1:0] in_bits;
    logic                   hv_valid;
    logic                   hv_ready;
    logic [HV_DIM-1:0]      hv_out;
`ifdef ENC_HV_COLLECT_DENSITY_EN
    logic [DENS_W-1:0]      hv_density;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [HV_DIM-1:0]      exp_alt;
    logic [DIMS_PER_CC-1:0] ones_c;

    enc_hv_collect dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ctr        (ctr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .hv_valid   (hv_valid),
        .hv_ready   (hv_ready),
        .hv_out     (hv_out)
`ifdef ENC_HV_COLLECT_DENSITY_EN
        ,
        .hv_density (hv_density)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DIMS_PER_CC-1:0] b);
        in_valid = 1'b1;
        in_bits  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_bits = '0; hv_ready = 1'b0;
        step(); step();
        n_checks++;
        if (ctr !== '0 || in_ready !== 1'b1 || hv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ctr=%0d in_ready=%b hv_valid=%b, want 0/1/0", ctr, in_ready, hv_valid);
        end
        n_checks++;
        if (hv_out !== '0) begin
            n_fail++;
            $display("FAIL reset_hv: hv_out popcount=%0d, want 0", $countones(hv_out));
        end
`ifdef ENC_HV_COLLECT_DENSITY_EN
        n_checks++;
        if (hv_density !== '0) begin
            n_fail++;
            $display("FAIL reset_density: got %0d want 0", hv_density);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_collect();
        hv_ready = 1'b1;
        for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
            n_checks++;
            if (ctr !== CTR_W'(k)) begin
                n_fail++;
                $display("FAIL full_ctr: got %0d want %0d", ctr, k);
            end
            send({DIMS_PER_CC{k[0]}});
        end
        n_checks++;
        if (hv_valid !== 1'b1 || in_ready !== 1'b0 || ctr !== '0) begin
            n_fail++;
            $display("FAIL full_done: hv_valid=%b in_ready=%b ctr=%0d, want 1/0/0", hv_valid, in_ready, ctr);
        end
        n_checks++;
        if (hv_out !== exp_alt) begin
            n_fail++;
            $display("FAIL full_hv: lo=%h hi=%h, want alternating chunks", hv_out[DIMS_PER_CC-1:0], hv_out[HV_DIM-1 -: 8]);
        end
`ifdef ENC_HV_COLLECT_DENSITY_EN
        n_checks++;
        if (hv_density !== DENS_W'(2500)) begin
            n_fail++;
            $display("FAIL full_density: got %0d want 2500", hv_density);
        end
`endif
        step();
        n_checks++;
        if (hv_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_handshake: hv_valid=%b in_ready=%b, want 0/1", hv_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [HV_DIM-1:0] exp_bp;
        int bad;
        exp_bp = '0;
        for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
            if (k < 3) exp_bp[k*DIMS_PER_CC +: DIMS_PER_CC] = ones_c;
        end
        hv_ready = 1'b0;
        for (int k = 0; k < int'(NUM_CHUNKS); k++) send((k < 3) ? ones_c : '0);
        bad = 0;
        in_valid = 1'b1;
        in_bits  = ones_c;
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if (in_ready !== 1'b0 || hv_valid !== 1'b1 || hv_out !== exp_bp) begin
                n_fail++;
                bad++;
                if (bad < 3) $display("FAIL bp_hold: cycle %0d in_ready=%b hv_valid=%b hv_pop=%0d, want 0/1/1500",
                                      c, in_ready, hv_valid, $countones(hv_out));
            end
            step();
        end
        in_valid = 1'b0;
`ifdef ENC_HV_COLLECT_DENSITY_EN
        n_checks++;
        if (hv_density !== DENS_W'(1500)) begin
            n_fail++;
            $display("FAIL bp_density: got %0d want 1500", hv_density);
        end
`endif
        hv_ready = 1'b1;
        step();
        n_checks++;
        if (hv_valid !== 1'b0 || in_ready !== 1'b1 || ctr !== '0) begin
            n_fail++;
            $display("FAIL bp_release: hv_valid=%b in_ready=%b ctr=%0d, want 0/1/0", hv_valid, in_ready, ctr);
        end
    endtask

    task automatic test_gapped();
        int k;
        int bad;
        k = 0;
        bad = 0;
        hv_ready = 1'b0;
        for (int c = 0; c < 3 * int'(NUM_CHUNKS) - 2; c++) begin
            if (c % 3 == 0) begin
                send({DIMS_PER_CC{k[0]}});
                k++;
            end else begin
                in_valid = 1'b0;
                in_bits  = ~{DIMS_PER_CC{k[0]}};
                step();
                n_checks++;
                if (ctr !== CTR_W'(k % int'(NUM_CHUNKS))) begin
                    n_fail++;
                    bad++;
                    if (bad < 3) $display("FAIL gap_ctr: got %0d want %0d", ctr, k % int'(NUM_CHUNKS));
                end
            end
        end
        n_checks++;
        if (hv_valid !== 1'b1 || hv_out !== exp_alt) begin
            n_fail++;
            $display("FAIL gap_result: hv_valid=%b hv_pop=%0d, want 1/2500 alternating", hv_valid, $countones(hv_out));
        end
        hv_ready = 1'b1;
        step();
    endtask

    task automatic test_flush();
        hv_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(ones_c);
        flush = 1'b1; in_valid = 1'b1; in_bits = ones_c;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (ctr !== '0 || hv_out !== '0 || hv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mid: ctr=%0d hv_pop=%0d hv_valid=%b, want 0/0/0", ctr, $countones(hv_out), hv_valid);
        end
        for (int k = 0; k < int'(NUM_CHUNKS); k++) send(ones_c);
        n_checks++;
        if (hv_valid !== 1'b1 || hv_out !== {HV_DIM{1'b1}}) begin
            n_fail++;
            $display("FAIL flush_refill: hv_valid=%b hv_pop=%0d, want 1/5000", hv_valid, $countones(hv_out));
        end
`ifdef ENC_HV_COLLECT_DENSITY_EN
        n_checks++;
        if (hv_density !== DENS_W'(5000)) begin
            n_fail++;
            $display("FAIL flush_density: got %0d want 5000", hv_density);
        end
`endif
        // flush in hold must not disturb the completed vector
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (hv_valid !== 1'b1 || hv_out !== {HV_DIM{1'b1}}) begin
            n_fail++;
            $display("FAIL flush_hold: hv_valid=%b hv_pop=%0d, want 1/5000", hv_valid, $countones(hv_out));
        end
        hv_ready = 1'b1;
        step();
        hv_ready = 1'b0;
        for (int k = 0; k < int'(NUM_CHUNKS) - 1; k++) send(ones_c);
        flush = 1'b1; in_valid = 1'b1; in_bits = ones_c;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (hv_valid !== 1'b0 || ctr !== '0 || hv_out !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_last: hv_valid=%b ctr=%0d hv_pop=%0d in_ready=%b, want 0/0/0/1",
                     hv_valid, ctr, $countones(hv_out), in_ready);
        end
    endtask

    task automatic test_async_reset();
        hv_ready = 1'b1;
        for (int k = 0; k < 6; k++) send(ones_c);
        n_checks++;
        if (ctr !== CTR_W'(6)) begin
            n_fail++;
            $display("FAIL areset_pre: ctr=%0d want 6", ctr);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ctr !== '0 || hv_out !== '0 || in_ready !== 1'b1 || hv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: ctr=%0d hv_pop=%0d in_ready=%b hv_valid=%b, want 0/0/1/0",
                     ctr, $countones(hv_out), in_ready, hv_valid);
        end
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
            n_checks++;
            if (ctr !== CTR_W'(k)) begin
                n_fail++;
                $display("FAIL areset_ctr: got %0d want %0d", ctr, k);
            end
            send({DIMS_PER_CC{k[0]}});
        end
        n_checks++;
        if (hv_valid !== 1'b1 || hv_out !== exp_alt) begin
            n_fail++;
            $display("FAIL areset_rerun: hv_valid=%b hv_pop=%0d, want 1/2500", hv_valid, $countones(hv_out));
        end
        step();
    endtask

    initial begin
        ones_c  = '1;
        exp_alt = '0;
        for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
            exp_alt[k*DIMS_PER_CC +: DIMS_PER_CC] = {DIMS_PER_CC{k[0]}};
        end
        test_reset();
        test_full_collect();
        test_backpressure();
        test_gapped();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_hv_collect.md
Name: enc_hv_collect

Overview:
- Output-side counterpart of the encoder's chunked input mux: the mux slices the HV_DIM-wide bundling array into DIMS_PER_CC-wide chunks, one per cycle, and this block collects the per-chunk bundled result bits back into one full HV_DIM-bit hypervector register.
- Owns the chunk counter that drives the mux select, so mux and collector stay in lockstep.
- Presents the completed hypervector downstream through a valid/ready handshake.

Parameters:
- HV_DIM, 5000, full hypervector dimensionality.
- DIMS_PER_CC, 500, dimensions produced per clock cycle; HV_DIM must be an exact multiple of it.
- NUM_CHUNKS, HV_DIM/DIMS_PER_CC (10), derived; chunks per hypervector.
- CTR_W, 4, chunk counter width; must satisfy 2**CTR_W >= NUM_CHUNKS.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- flush, input, 1, synchronous abort; discards the partial vector.
- ctr, output, CTR_W, current chunk index; drives the mux select.
- in_valid, input, 1, chunk bits valid this cycle.
- in_ready, output, 1, collector can accept a chunk.
- in_bits, input, DIMS_PER_CC, bundled result bits for chunk ctr.
- hv_valid, output, 1, hv_out holds a complete vector.
- hv_ready, input, 1, downstream accepts hv_out.
- hv_out, output, HV_DIM, assembled hypervector.
- hv_density, output, clog2(HV_DIM+1), count of set bits in hv_out. Exists only with the optional feature.

Behaviour:
- Reset (async, rst=1):
  - state=S_COLLECT, ctr=0, in_ready=1, hv_valid=0.
  - hv_out all zero; hv_density=0.
  - Reset mid-collection discards the partial vector with no output.
- State S_COLLECT:
  - in_ready=1.
  - On in_valid & in_ready: hv_out[ctr*DIMS_PER_CC +: DIMS_PER_CC] <= in_bits. Chunk 0 maps to bits [499:0] and chunk 9 to [4999:4500].
  - If ctr != NUM_CHUNKS-1: ctr <= ctr+1.
  - If ctr == NUM_CHUNKS-1: ctr <= 0, state <= S_HOLD, hv_valid <= 1 on the next cycle. Latency is 1 cycle from the last accepted chunk to hv_valid.
  - No in_valid: all registers hold; ctr does not advance.
- State S_HOLD:
  - in_ready=0, hv_valid=1.
  - hv_out is stable until the handshake completes; in_bits is ignored.
  - On hv_valid & hv_ready: hv_valid <= 0, state <= S_COLLECT. A new chunk 0 can be accepted on the following cycle; there is no same-cycle bypass.
  - hv_out is not cleared on handshake; every chunk is overwritten by the next collection.
- ctr range:
  - ctr never exceeds NUM_CHUNKS-1 and wraps to 0 only after the last chunk.
  - Values NUM_CHUNKS..2**CTR_W-1 are unreachable; an assertion checks this.
- flush:
  - In S_COLLECT: ctr <= 0 and the accumulator is reset; hv_out is cleared to zero; any chunk presented in the same cycle is dropped.
  - In S_HOLD: ignored. A completed vector is always delivered.
- Simultaneous flush and last chunk in S_COLLECT: flush wins, no hv_valid.
- Handshake rule: in_ready depends only on state, never combinationally on in_valid.

Optional Feature:
- Macro: ENC_HV_COLLECT_DENSITY_EN.
- With the macro:
  - A per-chunk popcount of in_bits accumulates into a density register on each accepted chunk.
  - The register is zeroed when chunk 0 is accepted, and on flush or reset.
  - hv_density is registered and valid together with hv_valid. It equals the popcount of hv_out.
- Without the macro: the port, the popcount logic and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package sparse_hdc_pkg holds:
  - HV_DIM, DIMS_PER_CC, NUM_CHUNKS, CTR_W.
  - DENS_W = $clog2(HV_DIM+1).
  - typedef enum logic {S_COLLECT, S_HOLD} coll_state_t.
- One natural sub-module: enc_chunk_popcount. It is a combinational DIMS_PER_CC-input popcount adder tree and is instantiated only under the macro.

Test Plan:
- Full collect: chunk k = {DIMS_PER_CC{k[0]}} for k=0..9, in_valid held high, hv_ready=1.
  - ctr steps 0..9; hv_valid rises 1 cycle after chunk 9.
  - hv_out[499:0]=0, hv_out[999:500]=all ones, alternating thereafter.
  - hv_density=2500.
- Backpressure: complete a vector with hv_ready=0 for 20 cycles.
  - in_ready=0 and hv_out stable throughout; chunks presented are ignored.
  - hv_ready=1 gives hv_valid=0 next cycle, then in_ready=1.
- Gapped input: in_valid toggled 1,0,0,1,…
  - ctr advances only on accepted chunks; the result equals the gap-free run.
- Flush mid-vector:
  - Flush after 4 chunks: ctr=0, hv_out=0.
  - A following 10 chunks of all ones give hv_out all ones and hv_density=5000.
  - Flush coincident with chunk 9: no hv_valid.
- Async reset: assert rst mid-cycle at ctr=6.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - The next run starts at chunk 0.
- Macro off: rerun the full-collect test; hv_out identical and no hv_density port present.
